// File: rtl/truth_table_sweeper.sv
// -----------------------------------------------------------------------------
// truth_table_sweeper
//
// Drives every combination of the four-input combinational expression block in
// ascending order, samples its three outputs after HOLD_CYCLES cycles of
// settling per pattern, and builds a 16-bit truth table plus a ones-count for
// each output. A single-cycle done pulse marks the end of a sweep.
//
// Parameters
//   HOLD_CYCLES  cycles each pattern is held before it is sampled (1..255)
//
// Ports
//   clk            system clock, rising edge
//   rst_n          asynchronous active-low reset
//   start          sweep request, only looked at while idle
//   a, b, c, d     stimulus; {a,b,c,d} is the current pattern index
//   s1_in..s3_in   outputs returned from the combinational block
//   busy           high while a sweep is running
//   done           one-cycle pulse when a sweep has completed
//   tt1..tt3       truth tables, bit i = output value for pattern i
//   ones1..ones3   number of ones in the matching truth table (0..16)
// -----------------------------------------------------------------------------
module truth_table_sweeper #(
    parameter int HOLD_CYCLES = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    output logic        a,
    output logic        b,
    output logic        c,
    output logic        d,
    input  logic        s1_in,
    input  logic        s2_in,
    input  logic        s3_in,
    output logic        busy,
    output logic        done,
    output logic [15:0] tt1,
    output logic [15:0] tt2,
    output logic [15:0] tt3,
    output logic [4:0]  ones1,
    output logic [4:0]  ones2,
    output logic [4:0]  ones3
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Last value of the hold counter inside a pattern window.
    localparam logic [7:0] HOLD_LAST = 8'(HOLD_CYCLES - 1);

    state_t     state;
    logic [3:0] idx;
    logic [7:0] hold_cnt;

    // Adds one sampled bit to a ones-count; 5 bits hold the full 0..16 range.
    function automatic logic [4:0] add_bit(input logic [4:0] cnt, input logic bit_in);
        return cnt + {4'b0000, bit_in};
    endfunction

    // The stimulus lines are registered copies of the pattern index so the
    // block under characterisation sees clean, glitch-free inputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            idx          <= 4'd0;
            hold_cnt     <= 8'd0;
            {a, b, c, d} <= 4'd0;
            busy         <= 1'b0;
            done         <= 1'b0;
            tt1          <= 16'h0000;
            tt2          <= 16'h0000;
            tt3          <= 16'h0000;
            ones1        <= 5'd0;
            ones2        <= 5'd0;
            ones3        <= 5'd0;
        end else begin
            case (state)
                IDLE: begin
                    {a, b, c, d} <= 4'd0;
                    busy         <= 1'b0;
                    done         <= 1'b0;
                    if (start) begin
                        state    <= RUN;
                        busy     <= 1'b1;
                        idx      <= 4'd0;
                        hold_cnt <= 8'd0;
                        tt1      <= 16'h0000;
                        tt2      <= 16'h0000;
                        tt3      <= 16'h0000;
                        ones1    <= 5'd0;
                        ones2    <= 5'd0;
                        ones3    <= 5'd0;
                    end
                end

                RUN: begin
                    if (hold_cnt == HOLD_LAST) begin
                        // End of this pattern's window: the block has had
                        // HOLD_CYCLES full cycles to settle.
                        tt1[idx] <= s1_in;
                        tt2[idx] <= s2_in;
                        tt3[idx] <= s3_in;
                        ones1    <= add_bit(ones1, s1_in);
                        ones2    <= add_bit(ones2, s2_in);
                        ones3    <= add_bit(ones3, s3_in);
                        hold_cnt <= 8'd0;
                        if (idx == 4'd15) begin
                            state        <= DONE;
                            busy         <= 1'b0;
                            done         <= 1'b1;
                            {a, b, c, d} <= 4'd0;
                        end else begin
                            idx          <= idx + 4'd1;
                            {a, b, c, d} <= idx + 4'd1;
                        end
                    end else begin
                        hold_cnt <= hold_cnt + 8'd1;
                    end
                end

                DONE: begin
                    // start is not sampled here; a held start is picked up
                    // in the following IDLE cycle.
                    state <= IDLE;
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    idx   <= 4'd0;
                end

                default: begin
                    state        <= IDLE;
                    busy         <= 1'b0;
                    done         <= 1'b0;
                    {a, b, c, d} <= 4'd0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_truth_table_sweeper.sv
// -----------------------------------------------------------------------------
// tb_truth_table_sweeper
//
// Two sweepers (HOLD_CYCLES = 1 and 4) each drive their own model of the
// combinational block. Mode 0 models the real expression block from its known
// truth tables; mode 1 ties s1 high, s2 low and s3 to d.
// -----------------------------------------------------------------------------
module tb_truth_table_sweeper;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        start  [2];
    logic        a_w    [2];
    logic        b_w    [2];
    logic        c_w    [2];
    logic        d_w    [2];
    logic        s1_w   [2];
    logic        s2_w   [2];
    logic        s3_w   [2];
    logic        busy_w [2];
    logic        done_w [2];
    logic [15:0] tt1_w  [2];
    logic [15:0] tt2_w  [2];
    logic [15:0] tt3_w  [2];
    logic [4:0]  ones1_w[2];
    logic [4:0]  ones2_w[2];
    logic [4:0]  ones3_w[2];
    int          mode   [2];

    // Truth tables of the real expression block, bit i = output for pattern i.
    logic [15:0] ref1 = 16'hF0FF;
    logic [15:0] ref2 = 16'hEEE0;
    logic [15:0] ref3 = 16'h3F77;

    for (genvar gi = 0; gi < 2; gi++) begin : g_block
        logic [3:0] pat;
        assign pat       = {a_w[gi], b_w[gi], c_w[gi], d_w[gi]};
        assign s1_w[gi]  = (mode[gi] == 0) ? ref1[pat] : 1'b1;
        assign s2_w[gi]  = (mode[gi] == 0) ? ref2[pat] : 1'b0;
        assign s3_w[gi]  = (mode[gi] == 0) ? ref3[pat] : d_w[gi];
    end

    truth_table_sweeper #(.HOLD_CYCLES(1)) u_h1 (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start[0]),
        .a     (a_w[0]),
        .b     (b_w[0]),
        .c     (c_w[0]),
        .d     (d_w[0]),
        .s1_in (s1_w[0]),
        .s2_in (s2_w[0]),
        .s3_in (s3_w[0]),
        .busy  (busy_w[0]),
        .done  (done_w[0]),
        .tt1   (tt1_w[0]),
        .tt2   (tt2_w[0]),
        .tt3   (tt3_w[0]),
        .ones1 (ones1_w[0]),
        .ones2 (ones2_w[0]),
        .ones3 (ones3_w[0])
    );

    truth_table_sweeper #(.HOLD_CYCLES(4)) u_h4 (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start[1]),
        .a     (a_w[1]),
        .b     (b_w[1]),
        .c     (c_w[1]),
        .d     (d_w[1]),
        .s1_in (s1_w[1]),
        .s2_in (s2_w[1]),
        .s3_in (s3_w[1]),
        .busy  (busy_w[1]),
        .done  (done_w[1]),
        .tt1   (tt1_w[1]),
        .tt2   (tt2_w[1]),
        .tt3   (tt3_w[1]),
        .ones1 (ones1_w[1]),
        .ones2 (ones2_w[1]),
        .ones3 (ones3_w[1])
    );

    typedef struct {
        int          inst;
        int          hold;
        int          mode;
        logic [15:0] t1;
        logic [15:0] t2;
        logic [15:0] t3;
        logic [4:0]  o1;
        logic [4:0]  o2;
        logic [4:0]  o3;
    } vec_t;

    vec_t vecs [4];
    int   n_pass;
    int   n_total;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    function automatic logic [3:0] pat_of(input int i);
        return {a_w[i], b_w[i], c_w[i], d_w[i]};
    endfunction

    // Pulses start for one cycle and follows the sweep, sampling at negedges.
    // lat counts cycles after the accepting edge until done is seen.
    task automatic run_sweep(input int inst, input int h, input bit noise,
                             output int lat, output int pat_err,
                             output int busy_err, output int after_bad);
        lat = -1; pat_err = 0; busy_err = 0; after_bad = 0;
        @(negedge clk); start[inst] = 1'b1;
        @(negedge clk); start[inst] = 1'b0;
        for (int n = 1; n <= 16 * h + 10; n++) begin
            if (done_w[inst]) begin
                lat = n;
                if (busy_w[inst]) busy_err++;
                break;
            end
            if (n <= 16 * h) begin
                if (pat_of(inst) != 4'((n - 1) / h)) pat_err++;
                if (!busy_w[inst]) busy_err++;
            end
            if (noise) start[inst] = ((n % 3) == 0);
            @(negedge clk);
        end
        start[inst] = 1'b0;
        @(negedge clk);
        if (done_w[inst] || busy_w[inst] || pat_of(inst) != 4'd0) after_bad++;
    endtask

    task automatic check_results(input string tag, input int i, input vec_t v);
        check({tag, " tt1"},   tt1_w[i],   v.t1);
        check({tag, " tt2"},   tt2_w[i],   v.t2);
        check({tag, " tt3"},   tt3_w[i],   v.t3);
        check({tag, " ones1"}, ones1_w[i], v.o1);
        check({tag, " ones2"}, ones2_w[i], v.o2);
        check({tag, " ones3"}, ones3_w[i], v.o3);
    endtask

    task automatic check_zero(input string tag, input int i);
        check({tag, " ctrl"}, {pat_of(i), busy_w[i], done_w[i]}, 0);
        check({tag, " tt"},   {tt1_w[i], tt2_w[i], tt3_w[i]}, 0);
        check({tag, " ones"}, {ones1_w[i], ones2_w[i], ones3_w[i]}, 0);
    endtask

    initial begin
        int lat, pe, be, ab, cnt;
        bit found;

        n_pass = 0; n_total = 0;
        rst_n = 1'b0;
        start[0] = 1'b0; start[1] = 1'b0;
        mode[0] = 0; mode[1] = 0;

        vecs[0] = '{0, 1, 0, 16'hF0FF, 16'hEEE0, 16'h3F77, 5'd12, 5'd9, 5'd12};
        vecs[1] = '{1, 4, 0, 16'hF0FF, 16'hEEE0, 16'h3F77, 5'd12, 5'd9, 5'd12};
        vecs[2] = '{0, 1, 1, 16'hFFFF, 16'h0000, 16'hAAAA, 5'd16, 5'd0, 5'd8};
        vecs[3] = '{1, 4, 1, 16'hFFFF, 16'h0000, 16'hAAAA, 5'd16, 5'd0, 5'd8};

        repeat (3) @(negedge clk);
        check_zero("reset h1", 0);
        check_zero("reset h4", 1);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Table-driven sweeps.
        foreach (vecs[k]) begin
            mode[vecs[k].inst] = vecs[k].mode;
            run_sweep(vecs[k].inst, vecs[k].hold, 1'b0, lat, pe, be, ab);
            check($sformatf("v%0d latency", k), lat, 16 * vecs[k].hold + 1);
            check($sformatf("v%0d pattern order", k), pe, 0);
            check($sformatf("v%0d busy", k), be, 0);
            check($sformatf("v%0d post-done idle", k), ab, 0);
            check_results($sformatf("v%0d", k), vecs[k].inst, vecs[k]);
        end

        // start toggled during RUN: exactly one done, order unaffected.
        mode[0] = 0;
        run_sweep(0, 1, 1'b1, lat, pe, be, ab);
        check("noise latency", lat, 17);
        check("noise pattern order", pe, 0);
        cnt = 0;
        repeat (20) begin
            @(negedge clk);
            if (done_w[0]) cnt++;
        end
        check("noise extra done", cnt, 0);
        check_results("noise", 0, vecs[0]);

        // start held high: back-to-back sweeps.
        @(negedge clk); start[0] = 1'b1;
        found = 1'b0;
        for (int n = 0; n < 40 && !found; n++) begin
            @(negedge clk);
            if (done_w[0]) found = 1'b1;
        end
        check("b2b first done", found, 1);
        @(negedge clk);
        check("b2b idle gap", {busy_w[0], done_w[0]}, 0);
        @(negedge clk);
        start[0] = 1'b0;
        check("b2b restarted busy", busy_w[0], 1);
        check("b2b cleared tt", {tt1_w[0], tt2_w[0], tt3_w[0]}, 0);
        check("b2b cleared ones", {ones1_w[0], ones2_w[0], ones3_w[0]}, 0);
        lat = -1;
        for (int n = 1; n <= 30; n++) begin
            if (done_w[0]) begin lat = n; break; end
            @(negedge clk);
        end
        check("b2b second latency", lat, 17);
        check_results("b2b", 0, vecs[0]);

        // Reset asserted at pattern 7 of an H=4 sweep.
        mode[1] = 0;
        @(negedge clk); start[1] = 1'b1;
        @(negedge clk); start[1] = 1'b0;
        found = 1'b0;
        for (int n = 0; n < 100 && !found; n++) begin
            if (pat_of(1) == 4'd7) found = 1'b1;
            else @(negedge clk);
        end
        check("reach pattern 7", found, 1);
        check("partial tt1 before reset", tt1_w[1], 16'h007F);
        #1 rst_n = 1'b0;
        #1 check_zero("mid reset", 1);
        cnt = 0;
        repeat (3) begin
            @(negedge clk);
            if (done_w[1]) cnt++;
        end
        check("mid reset no done", cnt, 0);
        rst_n = 1'b1;
        @(negedge clk);
        check("post reset idle", {busy_w[1], done_w[1]}, 0);
        run_sweep(1, 4, 1'b0, lat, pe, be, ab);
        check("after reset latency", lat, 65);
        check("after reset pattern order", pe, 0);
        check_results("after reset", 1, vecs[1]);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
